// File: rtl/lrc_holefill_stream.sv
// Row-buffered left-right consistency check with optional hole fill.
// A row of (dL, dR) pairs is captured, then replayed through a three-stage
// read/evaluate pipeline that honours downstream backpressure.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | parked; waits for enable, then samples width and mode
//   S_LOAD  | in_ready=1; writes L[x], R[x] until column W-1 is taken
//   S_CHECK | replays the row: S1 read L, S2 read R[x-dL], S3 evaluate/output
module lrc_holefill_stream #(
  parameter int DWIDTH    = 9,
  parameter int AWIDTH    = 11,
  parameter int MAX_WIDTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              enable,
  input  logic [AWIDTH-1:0] width,
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] range,
  input  logic [DWIDTH-1:0] thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] disp_L,
  input  logic [DWIDTH-1:0] disp_R,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] disp_out,
  output logic              out_last
);

  localparam int CW = ((AWIDTH > DWIDTH) ? AWIDTH : DWIDTH) + 1;
  localparam int MW = $clog2(MAX_WIDTH);
  localparam logic [DWIDTH-1:0] INVALID = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DWIDTH-1:0] r_mem_l [MAX_WIDTH];
  logic [DWIDTH-1:0] r_mem_r [MAX_WIDTH];
  logic [AWIDTH-1:0] r_wlast, r_wx, r_ix, r_x1, r_x2;
  logic [1:0]        r_mode;
  logic              r_issue_done, r_v1, r_v2;
  logic [DWIDTH-1:0] r_l_q, r_r_q, r_dl2, r_last_valid;
  logic              r_out_valid, r_out_last;
  logic [DWIDTH-1:0] r_disp_out;

  logic              w_in_hs, w_out_hs, w_row_end, w_adv, w_to_load, w_width_ok;
  logic [AWIDTH-1:0] w_wlast_new;
  logic              w_neg1, w_neg3, w_reject;
  logic [MW-1:0]     w_raddr;
  logic [DWIDTH:0]   w_diff, w_mag;
  logic [DWIDTH-1:0] w_result;

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign disp_out  = r_disp_out;

  assign w_in_hs   = clken && in_valid && in_ready;
  assign w_out_hs  = clken && r_out_valid && out_ready;
  assign w_row_end = w_out_hs && r_out_last;
  // The pipeline moves only when the output slot is empty or being drained.
  assign w_adv     = clken && (r_state == S_CHECK) && !(r_out_valid && !out_ready);
  assign w_to_load = clken && (w_next == S_LOAD) && (r_state != S_LOAD);

  // Zero or oversized widths fall back to the full buffer; W-1 is stored so it always fits.
  assign w_width_ok  = (width != '0) && (32'(width) <= 32'(MAX_WIDTH));
  assign w_wlast_new = w_width_ok ? (width - AWIDTH'(1)) : AWIDTH'(MAX_WIDTH - 1);

  // S2 address: x-dL, forced to 0 when dL>x (that pixel is rejected anyway).
  assign w_neg1  = CW'(r_l_q) > CW'(r_x1);
  assign w_raddr = w_neg1 ? '0 : MW'(r_x1 - AWIDTH'(r_l_q));

  // S3 evaluation in widened arithmetic so nothing wraps.
  assign w_neg3   = CW'(r_dl2) > CW'(r_x2);
  assign w_diff   = {1'b0, r_dl2} - {1'b0, r_r_q};
  assign w_mag    = w_diff[DWIDTH] ? -w_diff : w_diff;
  assign w_reject = (r_dl2 == INVALID) || (r_dl2 > range) || w_neg3 ||
                    (r_r_q == INVALID) || (w_mag > {1'b0, thresh});

  // Output value selection per latched mode.
  always_comb begin
    w_result = r_dl2;
    case (r_mode)
      2'd0:    w_result = r_dl2;
      2'd1:    w_result = w_reject ? INVALID : r_dl2;
      default: w_result = w_reject ? r_last_valid : r_dl2;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (clken && enable) w_next = S_LOAD;
      S_LOAD:  if (w_in_hs && (r_wx == r_wlast)) w_next = S_CHECK;
      S_CHECK: if (w_row_end) w_next = enable ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Row configuration, captured whenever a new row load begins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wlast <= '0;
      r_mode  <= '0;
    end else if (w_to_load) begin
      r_wlast <= w_wlast_new;
      r_mode  <= mode;
    end
  end

  // Row buffers: written during load, read by S1/S2 only when the pipeline advances.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_mem_l[r_wx[MW-1:0]] <= disp_L;
      r_mem_r[r_wx[MW-1:0]] <= disp_R;
    end
    if (w_adv) begin
      r_l_q <= r_mem_l[r_ix[MW-1:0]];
      r_r_q <= r_mem_r[w_raddr];
    end
  end

  // Load counter, issue counter and the S1..S3 pipeline with output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wx         <= '0;
      r_ix         <= '0;
      r_issue_done <= 1'b0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_dl2        <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_disp_out   <= '0;
      r_last_valid <= '0;
    end else if (w_to_load) begin
      r_wx         <= '0;
      r_ix         <= '0;
      r_issue_done <= 1'b0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_last_valid <= '0;
    end else begin
      if (w_in_hs) r_wx <= r_wx + AWIDTH'(1);
      if (w_adv) begin
        r_v1 <= !r_issue_done;
        r_x1 <= r_ix;
        if (!r_issue_done) begin
          r_ix <= r_ix + AWIDTH'(1);
          if (r_ix == r_wlast) r_issue_done <= 1'b1;
        end
        r_v2        <= r_v1;
        r_x2        <= r_x1;
        r_dl2       <= r_l_q;
        r_out_valid <= r_v2;
        r_out_last  <= r_v2 && (r_x2 == r_wlast);
        if (r_v2) begin
          r_disp_out <= w_result;
          if (r_mode[1] && !w_reject) r_last_valid <= r_dl2;
        end
      end
    end
  end

endmodule

// File: tb/tb_lrc_holefill_stream.sv
// Bench for lrc_holefill_stream: random rows checked against a per-pixel rule model.
module tb_lrc_holefill_stream;
  localparam int DW = 9;
  localparam int AW = 11;
  localparam int MAXW = 1024;
  localparam int INV = 511;

  logic clk = 1'b0;
  logic rst, clken, enable, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [AW-1:0] width;
  logic [1:0] mode;
  logic [DW-1:0] range, thresh, disp_L, disp_R, disp_out;

  int checks = 0;
  int errors = 0;
  int L_a[MAXW];
  int R_a[MAXW];
  int exp_q[$];

  lrc_holefill_stream #(.DWIDTH(DW), .AWIDTH(AW), .MAX_WIDTH(MAXW)) dut (
    .clk(clk), .rst(rst), .clken(clken), .enable(enable), .width(width), .mode(mode),
    .range(range), .thresh(thresh), .in_valid(in_valid), .in_ready(in_ready),
    .disp_L(disp_L), .disp_R(disp_R), .out_valid(out_valid), .out_ready(out_ready),
    .disp_out(disp_out), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Per-pixel rules applied directly to the stored row.
  task automatic model(input int w, input int md, input int rng, input int th);
    int lv, dl, dr, diff;
    bit ok;
    exp_q.delete();
    lv = 0;
    for (int x = 0; x < w; x++) begin
      dl = L_a[x];
      ok = 1;
      if (dl == INV || dl > rng || dl > x) ok = 0;
      if (ok) begin
        dr = R_a[x - dl];
        diff = (dl > dr) ? dl - dr : dr - dl;
        if (dr == INV || diff > th) ok = 0;
      end
      if (md == 0) exp_q.push_back(dl);
      else if (md == 1) exp_q.push_back(ok ? dl : INV);
      else begin
        if (ok) lv = dl;
        exp_q.push_back(lv);
      end
    end
  endtask

  task automatic fill_random(input int w);
    for (int x = 0; x < w; x++) begin
      L_a[x] = ($urandom_range(0, 9) == 0) ? INV : int'($urandom_range(0, 20));
      R_a[x] = ($urandom_range(0, 9) == 0) ? INV : int'($urandom_range(0, 20));
    end
  endtask

  task automatic run_row(input int width_in, input int md, input int rng, input int th,
                         input bit rand_ready, input bit rand_clken, input bit keep_en,
                         input int rst_after);
    int w_eff, x, idx, k, guard, first_k;
    bit stalled, prev_last;
    logic [DW-1:0] prev_d;
    w_eff = (width_in == 0 || width_in > MAXW) ? MAXW : width_in;
    model(w_eff, md, rng, th);
    @(negedge clk);
    width = AW'(width_in); mode = 2'(md); range = DW'(rng); thresh = DW'(th);
    enable = 1'b1; clken = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    x = 0; guard = 0;
    while (x < w_eff && guard < 20000) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_out_idle x=%0d out_valid=%b want 0", x, out_valid);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      clken = rand_clken ? ($urandom_range(0, 3) != 0) : 1'b1;
      disp_L = DW'(L_a[x]); disp_R = DW'(R_a[x]);
      if (in_valid && in_ready && clken) x++;
      guard++;
    end
    checks++;
    if (x != w_eff) begin
      errors++;
      $display("FAIL load_timeout loaded=%0d want %0d", x, w_eff);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!keep_en) enable = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_stop in_ready=%b want 0 after %0d loads", in_ready, w_eff);
    end
    idx = 0; k = 0; first_k = -1; stalled = 0; guard = 0; prev_d = '0; prev_last = 0;
    while (idx < w_eff && guard < 40000) begin
      if (rst_after >= 0 && idx == rst_after) begin
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0 || disp_out !== '0) begin
          errors++;
          $display("FAIL reset_mid_check valid=%b ready=%b last=%b d=%0d want 0 0 0 0",
                   out_valid, in_ready, out_last, disp_out);
        end
        rst = 1'b1; clken = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_idle in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        return;
      end
      if (out_valid && first_k < 0) first_k = k;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || disp_out !== prev_d || out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold idx=%0d valid=%b d=%0d last=%b want 1 %0d %b",
                   idx, out_valid, disp_out, out_last, prev_d, prev_last);
        end
      end else if (out_valid) begin
        checks++;
        if (disp_out !== DW'(exp_q[idx]) || out_last !== (idx == w_eff - 1)) begin
          errors++;
          $display("FAIL pixel idx=%0d d=%0d last=%b want %0d %b",
                   idx, disp_out, out_last, exp_q[idx], (idx == w_eff - 1));
        end
      end
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      clken = rand_clken ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready && clken) begin
        idx++; stalled = 0;
      end else if (out_valid) begin
        stalled = 1; prev_d = disp_out; prev_last = out_last;
      end else stalled = 0;
      @(negedge clk);
      k++; guard++;
    end
    checks++;
    if (idx != w_eff) begin
      errors++;
      $display("FAIL out_timeout got=%0d want %0d", idx, w_eff);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== keep_en) begin
      errors++;
      $display("FAIL row_end out_valid=%b in_ready=%b want 0 %b", out_valid, in_ready, keep_en);
    end
    if (!rand_clken) begin
      checks++;
      if (first_k != 3) begin
        errors++;
        $display("FAIL latency first_valid_cycle=%0d want 3", first_k);
      end
    end
    out_ready = 1'b0; clken = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clken = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    width = '0; mode = '0; range = '0; thresh = '0; disp_L = '0; disp_R = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || disp_out !== '0) begin
      errors++;
      $display("FAIL reset ready=%b valid=%b last=%b d=%0d want 0 0 0 0",
               in_ready, out_valid, out_last, disp_out);
    end
    enable = 1'b0; clken = 1'b1; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lrc_basic();
    L_a[0] = 0; L_a[1] = 1; L_a[2] = 1; L_a[3] = 3;
    R_a[0] = 0; R_a[1] = 0; R_a[2] = 5; R_a[3] = 0;
    run_row(4, 1, 64, 0, 0, 0, 0, -1);
    run_row(4, 2, 64, 0, 0, 0, 0, -1);
    L_a[0] = 5;
    run_row(4, 2, 64, 0, 0, 0, 0, -1);
    L_a[0] = 2; L_a[1] = 1; L_a[2] = 2; L_a[3] = 1;
    R_a[0] = 3; R_a[1] = 1; R_a[2] = 4; R_a[3] = 9;
    run_row(4, 3, 64, 1, 0, 0, 0, -1);
  endtask

  task automatic test_bypass_ramp();
    for (int x = 0; x < 8; x++) begin
      L_a[x] = x; R_a[x] = int'($urandom_range(0, 511));
    end
    run_row(8, 0, 3, 0, 0, 0, 0, -1);
  endtask

  task automatic test_random_rows();
    for (int n = 0; n < 6; n++) begin
      int w;
      w = int'($urandom_range(1, 40));
      fill_random(w);
      run_row(w, int'($urandom_range(0, 3)), int'($urandom_range(8, 30)),
              int'($urandom_range(0, 6)), 1, 0, 0, -1);
    end
  endtask

  task automatic test_backpressure();
    fill_random(16);
    run_row(16, 2, 25, 3, 1, 0, 0, -1);
    fill_random(20);
    run_row(20, 1, 25, 2, 1, 1, 0, -1);
  endtask

  task automatic test_range_boundary();
    for (int x = 0; x < 40; x++) begin
      L_a[x] = 0; R_a[x] = 0;
    end
    L_a[30] = 21; R_a[9] = 21;
    L_a[31] = 20; R_a[11] = 20;
    run_row(40, 1, 20, 0, 0, 0, 0, -1);
  endtask

  task automatic test_width_clamp();
    fill_random(MAXW);
    run_row(0, 1, 30, 4, 1, 0, 0, -1);
    fill_random(MAXW);
    run_row(1500, 2, 30, 4, 0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    fill_random(12);
    run_row(12, 2, 25, 3, 1, 0, 1, -1);
    fill_random(12);
    run_row(12, 2, 25, 3, 1, 0, 0, -1);
  endtask

  task automatic test_reset_mid_check();
    fill_random(8);
    run_row(8, 1, 25, 3, 0, 0, 1, 2);
    L_a[0] = 0; L_a[1] = 1; L_a[2] = 0; L_a[3] = 2;
    R_a[0] = 1; R_a[1] = 0; R_a[2] = 7; R_a[3] = 0;
    run_row(4, 1, 25, 1, 0, 0, 0, -1);
  endtask

  task automatic test_idle_park();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_park cycle=%0d in_ready=%b out_valid=%b want 0 0", i, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lrc_basic();
    test_bypass_ramp();
    test_idle_park();
    test_random_rows();
    test_backpressure();
    test_range_boundary();
    test_back_to_back();
    test_reset_mid_check();
    test_width_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
